// File: rtl/serial_subtractor_nbit_pkg.sv
// ============================================================================
// serial_subtractor_nbit_pkg : shared state encoding and overflow helper
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_subtractor_nbit_pkg;

  // 2'd3 is unreachable; the FSM decodes it as IDLE so a corrupted state recovers.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2,
    ST_RSVD  = 2'd3
  } state_e;

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_nbit_if.sv
// ============================================================================
// serial_subtractor_nbit_if : start/done operand and result bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface serial_subtractor_nbit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (output start, a, b, input busy, done, d, bout, ovf);
  modport slave  (input start, a, b, output busy, done, d, bout, ovf);
endinterface

`default_nettype wire

// File: rtl/serial_subtractor_nbit_full_sub.sv
// ============================================================================
// full_sub_one_bit : combinational one-bit full subtractor cell
// Rev 1.0
// ============================================================================
`default_nettype none

module full_sub_one_bit (
  input  wire logic a_i,
  input  wire logic b_i,
  input  wire logic bin_i,
  output logic      d_o,
  output logic      bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

`default_nettype wire

// File: rtl/serial_subtractor_nbit.sv
// ============================================================================
// serial_subtractor_nbit : bit-serial A-B, LSB first, WIDTH+1 cycles per result
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor_nbit
  import serial_subtractor_nbit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  serial_subtractor_nbit_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             accept_w;
  logic             last_w;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, d_sr_q, d_sr_d;
  logic             borrow_q;
  logic             a_msb_q, b_msb_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q, ovf_q;
  logic             cell_d_w, cell_bout_w;

  full_sub_one_bit u_cell (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cell_d_w),
    .bout_o (cell_bout_w)
  );

  assign last_w = (cnt_q == CNT_W'(WIDTH - 1));
  assign d_sr_d = {cell_d_w, d_sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // START is only honoured outside SHIFT; IDLE, FIN and the spare code share that path.
  always_comb begin
    state_d  = ST_IDLE;
    accept_w = 1'b0;
    case (state_q)
      ST_SHIFT: state_d = last_w ? ST_FIN : ST_SHIFT;
      default: begin
        if (bus.start) begin
          accept_w = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept_w) begin
      cnt_q    <= '0;
      a_sr_q   <= bus.a;
      b_sr_q   <= bus.b;
      borrow_q <= 1'b0;
      a_msb_q  <= bus.a[WIDTH-1];
      b_msb_q  <= bus.b[WIDTH-1];
    end else if (state_q == ST_SHIFT) begin
      cnt_q    <= cnt_q + 1'b1;
      a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
      d_sr_q   <= d_sr_d;
      borrow_q <= cell_bout_w;
      if (last_w) begin
        d_q    <= d_sr_d;
        bout_q <= cell_bout_w;
        ovf_q  <= sub_ovf(a_msb_q, b_msb_q, cell_d_w);
      end
    end
  end

  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_FIN);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire
